g_hazard_scoreboard: RTL and testbench

//  Stall controller for the 5-stage MIPS core, fed directly by the D-stage instruction-class decode.

---
 rtl/g_hazard_scoreboard.sv | 160 ++++++++++++++++
 tb/tb_g_hazard_scoreboard.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/g_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// g_hazard_scoreboard
//   Stall controller for a 5-stage MIPS pipeline. It takes the D-stage
//   instruction-class flags and register fields, keeps its own shadow records
//   of the instructions now in E and M ({valid, dst, tnew}), and raises stall
//   when a D-stage source still waits on a result that forwarding cannot
//   supply in time. It also counts stalled cycles, saturating at all-ones.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   load/store/cal_r/cal_i    D-stage class flags (lw / sw / add,sub / ori,lui)
//   branch/lui/j_r/j_addr     D-stage class flags (beq / lui / jr / jal)
//   rs_d, rt_d, rd_d          D-stage register fields
//   stall                     RAW hazard: hold PC and IF/ID, bubble ID/EX
//   en_pc, en_fd              PC and IF/ID write enables (= ~stall)
//   flush_de                  insert a nop into ID/EX (= stall)
//   stall_cnt                 stalled cycles since reset (saturating)
// ---------------------------------------------------------------------------
module g_hazard_scoreboard #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             store,
    input  logic             cal_r,
    input  logic             cal_i,
    input  logic             branch,
    input  logic             lui,
    input  logic             j_r,
    input  logic             j_addr,
    input  logic [4:0]       rs_d,
    input  logic [4:0]       rt_d,
    input  logic [4:0]       rd_d,
    output logic             stall,
    output logic             en_pc,
    output logic             en_fd,
    output logic             flush_de,
    output logic [CNT_W-1:0] stall_cnt
);

    // tnew: cycles until the producer's result can be forwarded.
    typedef struct packed {
        logic       valid;
        logic [4:0] dst;
        logic [1:0] tnew;
    } rec_t;

    rec_t             e_q, e_d;
    rec_t             m_q, m_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic       rs_use, rt_use;
    logic [1:0] rs_tuse, rt_tuse;
    logic       d_valid;
    logic [4:0] d_dst;
    logic [1:0] d_tnew;

    // A source must wait if a producer in E or M holds its register and the
    // result appears later than the consumer needs it. $0 never hazards.
    function automatic logic src_hazard(input logic       use_src,
                                        input logic [4:0] src,
                                        input logic [1:0] tuse,
                                        input rec_t       e_rec,
                                        input rec_t       m_rec);
        return use_src && (src != 5'd0) &&
               ((e_rec.valid && (e_rec.dst == src) && (e_rec.tnew > tuse)) ||
                (m_rec.valid && (m_rec.dst == src) && (m_rec.tnew > tuse)));
    endfunction

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves a value unassigned and no latch is inferred.
        rs_use  = 1'b0;
        rs_tuse = 2'd0;
        rt_use  = 1'b0;
        rt_tuse = 2'd0;
        d_valid = 1'b0;
        d_dst   = 5'd0;
        d_tnew  = 2'd0;

        // lui carries the cal_i flag but never reads rs.
        if (branch || j_r) begin
            rs_use  = 1'b1;
            rs_tuse = 2'd0;
        end else if (cal_r || (cal_i && !lui) || load || store) begin
            rs_use  = 1'b1;
            rs_tuse = 2'd1;
        end

        // A store only needs its data operand once it reaches M.
        if (branch) begin
            rt_use  = 1'b1;
            rt_tuse = 2'd0;
        end else if (cal_r) begin
            rt_use  = 1'b1;
            rt_tuse = 2'd1;
        end else if (store) begin
            rt_use  = 1'b1;
            rt_tuse = 2'd2;
        end

        if (cal_r) begin
            d_valid = 1'b1;
            d_dst   = rd_d;
            d_tnew  = 2'd1;
        end else if (cal_i || load) begin
            d_valid = 1'b1;
            d_dst   = rt_d;
            d_tnew  = load ? 2'd2 : 2'd1;
        end else if (j_addr) begin
            d_valid = 1'b1;
            d_dst   = 5'd31;
            d_tnew  = 2'd0;
        end

        stall = src_hazard(rs_use, rs_d, rs_tuse, e_q, m_q) ||
                src_hazard(rt_use, rt_d, rt_tuse, e_q, m_q);

        // A stall turns the instruction entering E into a bubble. Writes to $0
        // are dropped so they can never match a consumer.
        if (stall) begin
            e_d = '0;
        end else begin
            e_d.valid = d_valid && (d_dst != 5'd0);
            e_d.dst   = d_dst;
            e_d.tnew  = d_tnew;
        end

        m_d.valid = e_q.valid;
        m_d.dst   = e_q.dst;
        m_d.tnew  = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;

        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the values that existed before this edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q         <= '0;
            m_q         <= '0;
            stall_cnt_q <= '0;
        end else begin
            e_q         <= e_d;
            m_q         <= m_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Records are zero while reset is held, so stall falls to 0 at once.
    assign en_pc     = ~stall;
    assign en_fd     = ~stall;
    assign flush_de  = stall;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_g_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_g_hazard_scoreboard
//   Drives decoded MIPS instruction sequences into the D stage. Each scenario
//   pushes the expected per-cycle stall pattern into a queue as it issues an
//   instruction; the patterns are popped and compared mid-cycle. A second
//   instance with a 2-bit counter exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_g_hazard_scoreboard;

    typedef enum {OP_NOP, OP_LW, OP_SW, OP_ADD, OP_ORI, OP_LUI, OP_BEQ, OP_JR, OP_JAL} op_e;

    typedef struct packed {
        logic       load, store, cal_r, cal_i, branch, lui, j_r, j_addr;
        logic [4:0] rs, rt, rd;
    } instr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        load, store, cal_r, cal_i, branch, lui, j_r, j_addr;
    logic [4:0]  rs_d, rt_d, rd_d;
    logic        stall, en_pc, en_fd, flush_de;
    logic [31:0] stall_cnt;
    logic        stall_s, en_pc_s, en_fd_s, flush_de_s;
    logic [1:0]  stall_cnt_s;

    int   checks = 0;
    int   errors = 0;
    int   exp_cnt = 0;
    logic exp_q[$];

    always #5 clk = ~clk;

    g_hazard_scoreboard #(.CNT_W(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .load(load), .store(store), .cal_r(cal_r), .cal_i(cal_i),
        .branch(branch), .lui(lui), .j_r(j_r), .j_addr(j_addr),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .stall(stall), .en_pc(en_pc), .en_fd(en_fd), .flush_de(flush_de),
        .stall_cnt(stall_cnt)
    );

    g_hazard_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .load(load), .store(store), .cal_r(cal_r), .cal_i(cal_i),
        .branch(branch), .lui(lui), .j_r(j_r), .j_addr(j_addr),
        .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
        .stall(stall_s), .en_pc(en_pc_s), .en_fd(en_fd_s), .flush_de(flush_de_s),
        .stall_cnt(stall_cnt_s)
    );

    function automatic instr_t mk(op_e op, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd);
        instr_t i;
        i = '0;
        i.rs = rs;
        i.rt = rt;
        i.rd = rd;
        case (op)
            OP_LW:   i.load = 1'b1;
            OP_SW:   i.store = 1'b1;
            OP_ADD:  i.cal_r = 1'b1;
            OP_ORI:  i.cal_i = 1'b1;
            OP_LUI:  begin i.cal_i = 1'b1; i.lui = 1'b1; end
            OP_BEQ:  i.branch = 1'b1;
            OP_JR:   i.j_r = 1'b1;
            OP_JAL:  i.j_addr = 1'b1;
            default: ;
        endcase
        return i;
    endfunction

    task automatic drive(instr_t i);
        load = i.load; store = i.store; cal_r = i.cal_r; cal_i = i.cal_i;
        branch = i.branch; lui = i.lui; j_r = i.j_r; j_addr = i.j_addr;
        rs_d = i.rs; rt_d = i.rt; rd_d = i.rd;
    endtask

    // Issue one instruction into D (called just after a rising edge). It is
    // held there for n_stall stalled cycles and leaves D on the next cycle.
    task automatic issue(string name, instr_t i, int n_stall);
        logic exp_s;
        for (int k = 0; k <= n_stall; k++) exp_q.push_back(k < n_stall);
        drive(i);
        for (int k = 0; k <= n_stall; k++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: scoreboard queue empty", name);
            end else begin
                exp_s = exp_q.pop_front();
                if (exp_s) exp_cnt++;
                if ({stall, en_pc, en_fd, flush_de} !== {exp_s, ~exp_s, ~exp_s, exp_s}) begin
                    errors++;
                    $display("FAIL %s cyc%0d: stall/en_pc/en_fd/flush_de got %b%b%b%b want %b%b%b%b",
                             name, k, stall, en_pc, en_fd, flush_de, exp_s, ~exp_s, ~exp_s, exp_s);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_cnt(string name);
        int exp_sat;
        exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
        @(negedge clk);
        checks++;
        if (stall_cnt !== 32'(exp_cnt)) begin
            errors++;
            $display("FAIL %s stall_cnt: got %0d want %0d", name, stall_cnt, exp_cnt);
        end
        checks++;
        if (stall_cnt_s !== 2'(exp_sat)) begin
            errors++;
            $display("FAIL %s stall_cnt_sat: got %0d want %0d", name, stall_cnt_s, exp_sat);
        end
        @(posedge clk);
        #1;
    endtask

    // Two nops age any producer out of E and M.
    task automatic drain();
        issue("drain0", mk(OP_NOP, 0, 0, 0), 0);
        issue("drain1", mk(OP_NOP, 0, 0, 0), 0);
    endtask

    task automatic test_reset();
        drive(mk(OP_NOP, 0, 0, 0));
        #2;
        checks++;
        if ({stall, en_pc, en_fd, flush_de} !== 4'b0110 || stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_init: stall/en_pc/en_fd/flush_de=%b%b%b%b cnt=%0d want 0110 cnt=0",
                     stall, en_pc, en_fd, flush_de, stall_cnt);
        end
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        issue("lu_lw",  mk(OP_LW, 0, 1, 0), 0);
        issue("lu_add", mk(OP_ADD, 1, 3, 2), 1);
        drain();
        check_cnt("load_use");
    endtask

    task automatic test_load_branch();
        issue("lb_lw",  mk(OP_LW, 0, 1, 0), 0);
        issue("lb_beq", mk(OP_BEQ, 1, 0, 0), 2);
        drain();
        check_cnt("load_branch");
    endtask

    task automatic test_store_and_jr();
        issue("sj_add", mk(OP_ADD, 2, 3, 1), 0);
        issue("sj_sw",  mk(OP_SW, 2, 1, 0), 0);
        drain();
        issue("sj_ori", mk(OP_ORI, 0, 1, 0), 0);
        issue("sj_jr",  mk(OP_JR, 1, 0, 0), 1);
        drain();
        check_cnt("store_jr");
    endtask

    task automatic test_no_stall();
        issue("ns_jal",  mk(OP_JAL, 0, 0, 0), 0);
        issue("ns_jr31", mk(OP_JR, 31, 0, 0), 0);
        issue("ns_lw0",  mk(OP_LW, 0, 0, 0), 0);
        issue("ns_add0", mk(OP_ADD, 0, 0, 2), 0);
        issue("ns_lui1", mk(OP_LUI, 0, 1, 0), 0);
        issue("ns_lui2", mk(OP_LUI, 1, 2, 0), 0);
        drain();
        issue("ns_lw1",  mk(OP_LW, 0, 1, 0), 0);
        issue("ns_nop",  mk(OP_NOP, 0, 0, 0), 0);
        issue("ns_add1", mk(OP_ADD, 1, 4, 2), 0);
        drain();
        check_cnt("no_stall");
    endtask

    // M-stage hazard on rt, then a load feeding a store's data operand.
    task automatic test_back_to_back();
        issue("bb_lw",   mk(OP_LW, 0, 5, 0), 0);
        issue("bb_nop",  mk(OP_NOP, 0, 0, 0), 0);
        issue("bb_beq",  mk(OP_BEQ, 0, 5, 0), 1);
        drain();
        issue("bb_lw2",  mk(OP_LW, 0, 6, 0), 0);
        issue("bb_sw",   mk(OP_SW, 0, 6, 0), 0);
        issue("bb_add",  mk(OP_ADD, 7, 8, 9), 0);
        issue("bb_jr9",  mk(OP_JR, 9, 0, 0), 1);
        drain();
        check_cnt("back_to_back");
    endtask

    task automatic test_reset_mid_stall();
        issue("rm_lw", mk(OP_LW, 0, 1, 0), 0);
        drive(mk(OP_BEQ, 1, 0, 0));
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL rm_prestall: stall got %b want 1", stall);
        end
        #1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({stall, en_pc, en_fd, flush_de} !== 4'b0110 || stall_cnt !== 32'd0 || stall_cnt_s !== 2'd0) begin
            errors++;
            $display("FAIL rm_async: stall/en_pc/en_fd/flush_de=%b%b%b%b cnt=%0d cnt_s=%0d want 0110 0 0",
                     stall, en_pc, en_fd, flush_de, stall_cnt, stall_cnt_s);
        end
        exp_cnt = 0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // The lw record was cleared, so the held beq no longer waits.
        issue("rm_beq_after", mk(OP_BEQ, 1, 0, 0), 0);
        issue("rm_lw2",  mk(OP_LW, 0, 3, 0), 0);
        issue("rm_add2", mk(OP_ADD, 3, 3, 4), 1);
        drain();
        check_cnt("after_reset");
    endtask

    initial begin
        drive(mk(OP_NOP, 0, 0, 0));
        test_reset();
        test_load_use();
        test_load_branch();
        test_store_and_jr();
        test_no_stall();
        test_back_to_back();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
